// File: rtl/regfile_wr_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
// Holds the state encodings and the hard-wired zero register address.
package regfile_wr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FORCE = 2'd2,
        ST_DRAIN = 2'd3
    } wr_state_t;

    localparam int REG_ZERO_ADDR = 0;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear-sweep sequencer: walks every register address once after reset
// and raises a sticky done flag the cycle after the last entry is written.
module regfile_clr_seq #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] clr_cnt,
    output logic                  clr_last,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    assign clr_last = en && (clr_cnt == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
            done    <= 1'b0;
        end else begin
            if (en) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (clr_last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Single write-port owner for the register file: clear sweep after reset, then
// WB-priority arbitration with a bounded host wait and a 1-entry WB holding slot.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | clearing entries 0..2**ADDR_WIDTH-1, pipe stalled
// ST_RUN   | WB writes first, host gets idle WB cycles
// ST_FORCE | host owns the port for one cycle, displaced WB goes to pend
// ST_DRAIN | pend written back, pipe stalled, WB must be idle
module regfile_wr_ctrl
    import regfile_wr_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 8,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_wena,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic                  host_valid,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic                  rf_wena,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  stall_req,
    output logic                  init_done,
    output logic                  err
);

    localparam int                    WAIT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO_ADDR);

    wr_state_t             state, state_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_cnt_nxt;
    logic                  pend_v, pend_v_nxt;
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic [DATA_WIDTH-1:0] pend_data, pend_data_nxt;
    logic                  err_nxt;

    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  clr_last;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_zero_block;

    regfile_clr_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ST_INIT),
        .clr_cnt  (clr_cnt),
        .clr_last (clr_last),
        .done     (init_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            wait_cnt  <= '0;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            pend_v    <= pend_v_nxt;
            pend_addr <= pend_addr_nxt;
            pend_data <= pend_data_nxt;
            err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = '0;
        pend_v_nxt    = pend_v;
        pend_addr_nxt = pend_addr;
        pend_data_nxt = pend_data;
        err_nxt       = err;
        wr_req        = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        host_ready    = 1'b0;
        stall_req     = 1'b0;

        case (state)
            ST_INIT: begin
                stall_req = 1'b1;
                wr_req    = 1'b1;
                wr_addr   = clr_cnt;
                if (clr_last) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wb_wena) begin
                    wr_req  = 1'b1;
                    wr_addr = wb_waddr;
                    wr_data = wb_wdata;
                end else begin
                    host_ready = 1'b1;
                    if (host_valid) begin
                        wr_req  = 1'b1;
                        wr_addr = host_addr;
                        wr_data = host_wdata;
                    end
                end
                // host blocked by WB this cycle: count it, force a slot at the limit
                if (host_valid && wb_wena) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_FORCE;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
            end
            ST_FORCE: begin
                stall_req  = 1'b1;
                host_ready = 1'b1;
                if (host_valid) begin
                    wr_req  = 1'b1;
                    wr_addr = host_addr;
                    wr_data = host_wdata;
                end
                if (wb_wena) begin
                    pend_v_nxt    = 1'b1;
                    pend_addr_nxt = wb_waddr;
                    pend_data_nxt = wb_wdata;
                    state_nxt     = ST_DRAIN;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                stall_req  = 1'b1;
                pend_v_nxt = 1'b0;
                if (pend_v) begin
                    wr_req  = 1'b1;
                    wr_addr = pend_addr;
                    wr_data = pend_data;
                end
                if (wb_wena) begin
                    err_nxt = 1'b1;
                end
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // the clear sweep must still write entry 0
    assign wr_zero_block = (ZERO_REG != 0) && (state != ST_INIT) && (wr_addr == ZERO_ADDR);
    assign rf_wena       = wr_req && !wr_zero_block;
    assign rf_waddr      = rf_wena ? wr_addr : '0;
    assign rf_wdata      = rf_wena ? wr_data : '0;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: one DUT with ZERO_REG=1 and a lockstep
// twin with ZERO_REG=0 sharing the same inputs.
module tb_regfile_wr_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_wena = 1'b0;
    logic [AW-1:0] wb_waddr = '0;
    logic [DW-1:0] wb_wdata = '0;
    logic          host_valid = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;

    logic          host_ready, rf_wena, stall_req, init_done, err;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          z0_host_ready, z0_rf_wena, z0_stall_req, z0_init_done, z0_err;
    logic [AW-1:0] z0_rf_waddr;
    logic [DW-1:0] z0_rf_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] shadow [32];

    regfile_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(8), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .wb_wena(wb_wena), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .init_done(init_done), .err(err)
    );

    regfile_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(8), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .rst(rst), .wb_wena(wb_wena), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .host_valid(host_valid), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(z0_host_ready), .rf_wena(z0_rf_wena), .rf_waddr(z0_rf_waddr),
        .rf_wdata(z0_rf_wdata), .stall_req(z0_stall_req), .init_done(z0_init_done), .err(z0_err)
    );

    always #5 clk = ~clk;

    // register file contents as seen through the write port of the ZERO_REG=1 DUT
    always @(posedge clk) begin
        if (rf_wena === 1'b1) shadow[rf_waddr] <= rf_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_wena    = 1'b0;
        wb_waddr   = '0;
        wb_wdata   = '0;
        host_valid = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
    endtask

    // eight WB-blocked cycles; leaves the DUT presenting its FORCE cycle
    task automatic stall_cycles(input logic [AW-1:0] h_addr, input logic [DW-1:0] h_data);
        host_valid = 1'b1;
        host_addr  = h_addr;
        host_wdata = h_data;
        for (int k = 0; k < 8; k++) begin
            wb_wena  = 1'b1;
            wb_waddr = AW'(20 + k);
            wb_wdata = 32'hF00 + 32'(k);
            step();
        end
    endtask

    task automatic check_sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            #2;
            n_tests++;
            if (rf_wena !== 1'b1 || rf_waddr !== AW'(i) || rf_wdata !== '0 || stall_req !== 1'b1 ||
                host_ready !== 1'b0 || init_done !== 1'b0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_%0d: wena=%b addr=%0d data=%h stall=%b rdy=%b done=%b err=%b, required 1 %0d 0 1 0 0 0",
                         tag, i, rf_wena, rf_waddr, rf_wdata, stall_req, host_ready, init_done, err, i);
            end
            step();
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wb_wena    = 1'b1;
        wb_waddr   = 5'd5;
        wb_wdata   = 32'hFFFF_FFFF;
        host_valid = 1'b1;
        host_addr  = 5'd6;
        host_wdata = 32'h1234;
        check_sweep("sweep");
        idle();
        #2;
        n_tests++;
        if (init_done !== 1'b1 || stall_req !== 1'b0 || rf_wena !== 1'b0 || host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_sweep: done=%b stall=%b wena=%b rdy=%b, required 1 0 0 1",
                     init_done, stall_req, rf_wena, host_ready);
        end
        step();
    endtask

    task automatic test_wb_priority();
        wb_wena = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'hDEAD;
        host_valid = 1'b1; host_addr = 5'd4; host_wdata = 32'h4444;
        #2;
        n_tests++;
        if (rf_wena !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEAD || host_ready !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_first: wena=%b addr=%0d data=%h rdy=%b stall=%b, required 1 3 dead 0 0",
                     rf_wena, rf_waddr, rf_wdata, host_ready, stall_req);
        end
        step();
        wb_wena = 1'b0;
        #2;
        n_tests++;
        if (rf_wena !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h4444 || host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL host_next: wena=%b addr=%0d data=%h rdy=%b, required 1 4 4444 1",
                     rf_wena, rf_waddr, rf_wdata, host_ready);
        end
        step();
        idle();
    endtask

    task automatic test_force();
        host_valid = 1'b1; host_addr = 5'd9; host_wdata = 32'h99;
        for (int k = 0; k < 9; k++) begin
            wb_wena  = 1'b1;
            wb_waddr = AW'(10 + k);
            wb_wdata = 32'h100 + 32'(k);
            #2;
            n_tests++;
            if (k < 8) begin
                if (rf_wena !== 1'b1 || rf_waddr !== AW'(10 + k) || rf_wdata !== 32'h100 + 32'(k) ||
                    host_ready !== 1'b0 || stall_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL starve_%0d: wena=%b addr=%0d data=%h rdy=%b stall=%b, required 1 %0d %h 0 0",
                             k, rf_wena, rf_waddr, rf_wdata, host_ready, stall_req, 10 + k, 32'h100 + 32'(k));
                end
            end else begin
                if (rf_wena !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 ||
                    host_ready !== 1'b1 || stall_req !== 1'b1) begin
                    n_fail++;
                    $display("FAIL force_slot: wena=%b addr=%0d data=%h rdy=%b stall=%b, required 1 9 99 1 1",
                             rf_wena, rf_waddr, rf_wdata, host_ready, stall_req);
                end
            end
            step();
        end
        idle();
        #2;
        n_tests++;
        if (rf_wena !== 1'b1 || rf_waddr !== 5'd18 || rf_wdata !== 32'h108 || host_ready !== 1'b0 || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_slot: wena=%b addr=%0d data=%h rdy=%b stall=%b, required 1 18 108 0 1",
                     rf_wena, rf_waddr, rf_wdata, host_ready, stall_req);
        end
        step();
        #2;
        n_tests++;
        if (stall_req !== 1'b0 || rf_wena !== 1'b0 || host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_drain: stall=%b wena=%b rdy=%b, required 0 0 1", stall_req, rf_wena, host_ready);
        end
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (shadow[10 + k] !== 32'h100 + 32'(k)) begin
                n_fail++;
                $display("FAIL wb_kept_%0d: reg%0d=%h, required %h", k, 10 + k, shadow[10 + k], 32'h100 + 32'(k));
            end
        end
        n_tests++;
        if (shadow[9] !== 32'h99) begin
            n_fail++;
            $display("FAIL host_kept: reg9=%h, required 99", shadow[9]);
        end
        step();
    endtask

    task automatic test_same_addr();
        stall_cycles(5'd7, 32'h1);
        wb_wena = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h2;
        #2;
        n_tests++;
        if (rf_wena !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1 || stall_req !== 1'b1) begin
            n_fail++;
            $display("FAIL same_force: wena=%b addr=%0d data=%h stall=%b, required 1 7 1 1",
                     rf_wena, rf_waddr, rf_wdata, stall_req);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (shadow[7] !== 32'h1 || rf_wena !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2) begin
            n_fail++;
            $display("FAIL same_drain: reg7=%h wena=%b addr=%0d data=%h, required 1 1 7 2",
                     shadow[7], rf_wena, rf_waddr, rf_wdata);
        end
        step();
        n_tests++;
        if (shadow[7] !== 32'h2) begin
            n_fail++;
            $display("FAIL same_final: reg7=%h, required 2", shadow[7]);
        end
    endtask

    task automatic test_zero_reg();
        wb_wena = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'h55;
        host_valid = 1'b1; host_addr = 5'd0; host_wdata = 32'h66;
        #2;
        n_tests++;
        if (rf_wena !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== '0 || host_ready !== 1'b0 ||
            z0_rf_wena !== 1'b1 || z0_rf_wdata !== 32'h55) begin
            n_fail++;
            $display("FAIL zero_wb: wena=%b addr=%0d data=%h rdy=%b z0_wena=%b z0_data=%h, required 0 0 0 0 1 55",
                     rf_wena, rf_waddr, rf_wdata, host_ready, z0_rf_wena, z0_rf_wdata);
        end
        step();
        wb_wena = 1'b0;
        #2;
        n_tests++;
        if (rf_wena !== 1'b0 || host_ready !== 1'b1 || z0_rf_wena !== 1'b1 || z0_rf_wdata !== 32'h66 ||
            z0_host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_host: wena=%b rdy=%b z0_wena=%b z0_data=%h z0_rdy=%b, required 0 1 1 66 1",
                     rf_wena, host_ready, z0_rf_wena, z0_rf_wdata, z0_host_ready);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (shadow[0] !== '0) begin
            n_fail++;
            $display("FAIL zero_kept: reg0=%h, required 0", shadow[0]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        stall_cycles(5'd13, 32'h13);
        wb_wena = 1'b1; wb_waddr = 5'd12; wb_wdata = 32'hABC;
        #2;
        n_tests++;
        if (stall_req !== 1'b1 || host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_force: stall=%b rdy=%b, required 1 1", stall_req, host_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        check_sweep("resweep");
        #2;
        n_tests++;
        if (rf_wena !== 1'b0 || init_done !== 1'b1 || err !== 1'b0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_dropped: wena=%b done=%b err=%b stall=%b, required 0 1 0 0",
                     rf_wena, init_done, err, stall_req);
        end
        step();
        n_tests++;
        if (shadow[12] !== '0 || shadow[13] !== '0) begin
            n_fail++;
            $display("FAIL mid_regs: reg12=%h reg13=%h, required 0 0", shadow[12], shadow[13]);
        end
    endtask

    task automatic test_err();
        stall_cycles(5'd15, 32'h15);
        wb_wena = 1'b1; wb_waddr = 5'd16; wb_wdata = 32'h16;
        step();
        wb_wena = 1'b1; wb_waddr = 5'd14; wb_wdata = 32'h77;
        host_valid = 1'b0;
        #2;
        n_tests++;
        if (err !== 1'b0 || rf_waddr !== 5'd16 || rf_wdata !== 32'h16) begin
            n_fail++;
            $display("FAIL err_drain: err=%b addr=%0d data=%h, required 0 16 16", err, rf_waddr, rf_wdata);
        end
        step();
        idle();
        #2;
        n_tests++;
        if (err !== 1'b1 || z0_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b z0_err=%b, required 1 1", err, z0_err);
        end
        for (int k = 0; k < 3; k++) step();
        #2;
        n_tests++;
        if (err !== 1'b1 || shadow[14] !== '0 || stall_req !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b reg14=%h stall=%b, required 1 0 0", err, shadow[14], stall_req);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        n_tests++;
        if (err !== 1'b0 || init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b done=%b, required 0 0", err, init_done);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_wb_priority();
        test_force();
        test_same_addr();
        test_zero_reg();
        test_reset_mid();
        test_err();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
